// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRP read ports, clear
// sequencer and pending-write scoreboard. Optional REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   ready_o,
  input  logic [1:0]             we_i,
  input  logic [2*$clog2(NREG)-1:0] wa_i,
  input  logic [2*XLEN-1:0]      wd_i,
  input  logic [NRP*$clog2(NREG)-1:0] ra_i,
  output logic [NRP*XLEN-1:0]    rd_o,
  input  logic                   pend_set_i,
  input  logic [$clog2(NREG)-1:0] pend_addr_i,
  output logic [NRP-1:0]         rbusy_o
);

  localparam int AW = $clog2(NREG);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREG];

  logic            run;
  logic [1:0]      wacc;
  logic            pacc;
  logic [AW-1:0]   wa [2];
  logic [XLEN-1:0] wd [2];
  logic [AW-1:0]   ra [NRP];

  always_comb begin
    run = (state_q == RUN);
    for (int p = 0; p < 2; p++) begin
      wa[p]   = wa_i[p*AW +: AW];
      wd[p]   = wd_i[p*XLEN +: XLEN];
      wacc[p] = run && we_i[p] && (wa[p] != '0);
    end
    pacc = run && pend_set_i && (pend_addr_i != '0);
    for (int k = 0; k < NRP; k++) begin
      ra[k] = ra_i[k*AW +: AW];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(NREG - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // A fresh issue outranks a retiring write to the same register
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < 2; p++) begin
      if (wacc[p]) begin
        busy_d[wa[p]] = 1'b0;
      end
    end
    if (pacc) begin
      busy_d[pend_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (!run) begin
        mem_q[ptr_q] <= '0;
      end
      if (wacc[0] && !(wacc[1] && (wa[1] == wa[0]))) begin
        mem_q[wa[0]] <= wd[0];
      end
      if (wacc[1]) begin
        mem_q[wa[1]] <= wd[1];
      end
    end
  end

  always_comb begin
    rd_o    = '0;
    rbusy_o = '0;
    for (int k = 0; k < NRP; k++) begin
      rd_o[k*XLEN +: XLEN] = mem_q[ra[k]];
      rbusy_o[k]           = busy_q[ra[k]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (wacc[p] && (wa[p] == ra[k])) begin
          rd_o[k*XLEN +: XLEN] = wd[p];
          rbusy_o[k]           = 1'b0;
        end
      end
      if (pacc && (pend_addr_i == ra[k])) begin
        rbusy_o[k] = 1'b1;
      end
`endif
      if (!run || (ra[k] == '0)) begin
        rd_o[k*XLEN +: XLEN] = '0;
        rbusy_o[k]           = 1'b0;
      end
    end
  end

  assign ready_o = run;

endmodule
